// File: rtl/i2s_sample_port_pkg.sv
// Shared constants for the mono I2S sample port.
package i2s_sample_port_pkg;

  localparam int I2S_DATA_WIDTH  = 16;
  localparam int I2S_SYNC_STAGES = 2;

  // Bit counter must hold 0..data_width+1 (saturation value marks over-long slots).
  function automatic int i2s_bit_cnt_width(input int data_width);
    return $clog2(data_width + 2);
  endfunction

endpackage

// File: rtl/i2s_sample_port_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous codec pin with one-cycle edge strobes.
module sync_edge_detect
  import i2s_sample_port_pkg::*;
#(
  parameter int stages = I2S_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [stages-1:0] chain;
  logic              last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= (chain << 1) | stages'(async_in);
      last  <= chain[stages-1];
    end
  end

  assign sync_out = chain[stages-1];
  assign rise     = sync_out & ~last;
  assign fall     = ~sync_out & last;

endmodule

// File: rtl/i2s_sample_port.sv
// Mono I2S slave: left-slot word to the engine, engine answer replayed on both slots next frame.
module i2s_sample_port
  import i2s_sample_port_pkg::*;
#(
  parameter int data_width  = I2S_DATA_WIDTH,
  parameter int sync_stages = I2S_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_din,
  output logic                  i2s_dout,
  output logic [data_width-1:0] in_sample,
  output logic                  sample_ready,
  input  logic [data_width-1:0] out_sample,
  input  logic                  engine_ready,
  input  logic                  clear_flags,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int                    cnt_w    = i2s_bit_cnt_width(data_width);
  localparam logic [cnt_w-1:0]      cnt_max  = cnt_w'(data_width + 1);
  localparam logic [cnt_w-1:0]      cnt_last = cnt_w'(data_width);
  localparam logic [data_width-1:0] msb_mask = {1'b1, {(data_width-1){1'b0}}};

  logic bclk_sync, bclk_rise, bclk_fall;
  logic ws, ws_rise, ws_fall;
  logic din, din_rise, din_fall;
  logic unused_strobes;

  logic [cnt_w-1:0]      bit_cnt, cnt_next;
  logic                  ws_prev, aligned;
  logic [data_width-1:0] rx_shift, rx_bit;
  logic                  slot_edge, left_edge, right_edge;
  logic                  engine_ready_d, engine_rise;
  logic [data_width-1:0] pending, tx_word;
  logic                  pending_valid, outstanding;

  sync_edge_detect #(.stages(sync_stages)) u_bclk_sync (
    .clk(clk), .reset(reset), .async_in(i2s_bclk),
    .sync_out(bclk_sync), .rise(bclk_rise), .fall(bclk_fall)
  );

  sync_edge_detect #(.stages(sync_stages)) u_ws_sync (
    .clk(clk), .reset(reset), .async_in(i2s_lrclk),
    .sync_out(ws), .rise(ws_rise), .fall(ws_fall)
  );

  sync_edge_detect #(.stages(sync_stages)) u_din_sync (
    .clk(clk), .reset(reset), .async_in(i2s_din),
    .sync_out(din), .rise(din_rise), .fall(din_fall)
  );

  assign unused_strobes = ^{bclk_sync, ws_rise, ws_fall, din_rise, din_fall};

  // Slot framing: count restarts on any ws change; the k-th bit after it lands at data_width-k.
  always_comb begin
    slot_edge  = bclk_rise & (ws != ws_prev);
    left_edge  = slot_edge & ~ws;
    right_edge = slot_edge & ws;
    if (ws != ws_prev)
      cnt_next = '0;
    else if (bit_cnt == cnt_max)
      cnt_next = bit_cnt;
    else
      cnt_next = bit_cnt + cnt_w'(1);
    rx_bit = '0;
    if (din && (cnt_next != '0) && (cnt_next <= cnt_last))
      rx_bit = msb_mask >> (cnt_next - cnt_w'(1));
    engine_rise = engine_ready & ~engine_ready_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt      <= '0;
      ws_prev      <= 1'b0;
      aligned      <= 1'b0;
      rx_shift     <= '0;
      in_sample    <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= 1'b0;
      if (bclk_rise) begin
        bit_cnt <= cnt_next;
        ws_prev <= ws;
        if (left_edge) begin
          rx_shift <= '0;
          aligned  <= 1'b1;
        end else if (!ws) begin
          rx_shift <= rx_shift | rx_bit;
        end
        if (right_edge && aligned) begin
          in_sample    <= rx_shift;
          sample_ready <= 1'b1;
        end
      end
    end
  end

  // A capture in the same cycle as the left boundary stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      engine_ready_d <= 1'b0;
      pending        <= '0;
      pending_valid  <= 1'b0;
      outstanding    <= 1'b0;
      tx_word        <= '0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
      i2s_dout       <= 1'b0;
    end else begin
      engine_ready_d <= engine_ready;
      if (left_edge && aligned) begin
        if (pending_valid)
          tx_word <= pending;
        pending_valid <= 1'b0;
      end
      if (engine_rise) begin
        pending       <= out_sample;
        pending_valid <= 1'b1;
      end
      if (sample_ready)
        outstanding <= 1'b1;
      else if (engine_rise)
        outstanding <= 1'b0;
      if (clear_flags) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end
      if (sample_ready && outstanding)
        overrun <= 1'b1;
      if (left_edge && aligned && !pending_valid)
        underrun <= 1'b1;
      if (bclk_fall)
        i2s_dout <= |(tx_word & (msb_mask >> bit_cnt));
    end
  end

endmodule
